// File: rtl/bch_gf_pkg.sv
// GF(2^13) helpers shared by the BCH decoder: field constants, constant-multiplier
// matrix construction and the Chien-search FSM state type.
package bch_gf_pkg;

    localparam int M        = 13;
    localparam int GF_ORDER = (1 << M) - 1;
    localparam logic [M:0] PRIM_POLY = 14'h201B;  // x^13 + x^4 + x^3 + x + 1

    typedef logic [M-1:0]          gf_t;
    typedef logic [M-1:0][M-1:0]   gf_mat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } chien_state_t;

    function automatic gf_t gf_mul_alpha(input gf_t a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t acc = '0;
        gf_t sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc ^= sh;
            sh = gf_mul_alpha(sh);
        end
        return acc;
    endfunction

    // Square-and-multiply keeps elaboration cheap even for exponents near 8190.
    function automatic gf_t gf_alpha_pow(input int e);
        gf_t res  = gf_t'(1);
        gf_t base = gf_t'(2);
        int  r    = e % GF_ORDER;
        for (int i = 0; i < M; i++) begin
            if (r[i]) res = gf_mul(res, base);
            base = gf_mul(base, base);
        end
        return res;
    endfunction

    // Row i is the product alpha^e * alpha^i, i.e. the contribution of input bit i.
    function automatic gf_mat_t gf_const_matrix(input int e);
        gf_mat_t mat;
        gf_t     col = gf_alpha_pow(e);
        for (int i = 0; i < M; i++) begin
            mat[i] = col;
            col    = gf_mul_alpha(col);
        end
        return mat;
    endfunction

endpackage

// File: rtl/gf_const_mul.sv
// Combinational GF(2^13) constant multiplier: c = a * alpha^EXP as a fixed XOR network.
module gf_const_mul
    import bch_gf_pkg::*;
#(
    parameter int EXP = 1
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] c
);

    localparam gf_mat_t MAT = gf_const_matrix(EXP);

    // NOTE: assigning a default before the loop keeps this block free of inferred latches.
    always_comb begin
        c = '0;
        for (int i = 0; i < M; i++) begin
            if (a[i]) c ^= MAT[i];
        end
    end

endmodule

// File: rtl/bch_chien_search.sv
// Serial Chien search: evaluates the error-locator polynomial at one codeword
// position per cycle, flags roots, and reports the root count and decode failure.
module bch_chien_search
    import bch_gf_pkg::*;
#(
    parameter int T  = 32,
    parameter int N  = 8191,
    parameter int CW = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lambda_valid,
    output logic                 lambda_ready,
    input  logic [(T+1)*M-1:0]   lambda,
    input  logic [CW-1:0]        lambda_deg,
    output logic                 err_valid,
    output logic                 err_flag,
    output logic [12:0]          err_pos,
    output logic                 done,
    output logic [CW-1:0]        err_count,
    output logic                 fail
);

    // Shortened code: position N-1 corresponds to alpha^OFF, not alpha^1.
    localparam int            OFF      = (8192 - N) % GF_ORDER;
    localparam logic [12:0]   POS_LAST = 13'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    chien_state_t state, state_nxt;
    logic         load, step, finish;

    gf_t           lam0;
    logic [CW-1:0] deg;
    logic [12:0]   pos;
    gf_t           r      [1:T];
    gf_t           r_step [1:T];
    gf_t           r_init [1:T];
    gf_t           sum;

    for (genvar j = 1; j <= T; j++) begin : g_coef
        gf_const_mul #(.EXP(j)) u_step (
            .a (r[j]),
            .c (r_step[j])
        );
        gf_const_mul #(.EXP((j * OFF) % GF_ORDER)) u_off (
            .a (lambda[j*M +: M]),
            .c (r_init[j])
        );
    end

    always_comb begin
        sum = lam0;
        for (int j = 1; j <= T; j++) sum ^= r[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (lambda_valid && lambda_ready) state_nxt = ST_RUN;
            ST_RUN:  if (pos == '0) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load   = (state == ST_IDLE) && lambda_valid && lambda_ready;
        step   = (state == ST_RUN);
        finish = (state == ST_FIN);
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: coefficient registers are reset too, so an aborted search leaves no stale state.
            for (int j = 1; j <= T; j++) r[j] <= '0;
            lam0         <= '0;
            deg          <= '0;
            pos          <= '0;
            lambda_ready <= 1'b0;
            err_valid    <= 1'b0;
            err_flag     <= 1'b0;
            err_pos      <= '0;
            done         <= 1'b0;
            err_count    <= '0;
            fail         <= 1'b0;
        end else begin
            // Ready lags the IDLE state by one cycle, giving an N+3 cycle turnaround.
            lambda_ready <= (state == ST_IDLE) && !load;
            err_valid    <= step;
            done         <= finish;
            if (load) begin
                for (int j = 1; j <= T; j++) r[j] <= r_init[j];
                lam0      <= lambda[M-1:0];
                deg       <= lambda_deg;
                pos       <= POS_LAST;
                err_count <= '0;
                fail      <= 1'b0;
            end
            if (step) begin
                for (int j = 1; j <= T; j++) r[j] <= r_step[j];
                err_flag <= (sum == '0);
                err_pos  <= pos;
                pos      <= pos - 13'd1;
                if (sum == '0 && err_count != CNT_MAX) err_count <= err_count + 1'b1;
            end
            if (finish) begin
                fail <= (err_count != deg) || (int'(deg) > T) || (lam0 == '0);
            end
        end
    end

endmodule

// File: tb/tb_bch_chien_search.sv
// Bench for bch_chien_search: table vectors, random polynomials checked against a
// log/antilog Horner model, plus handshake and mid-search reset sequences.
module tb_bch_chien_search;

    localparam int M  = 13;
    localparam int T  = 32;
    localparam int N  = 1000;
    localparam int CW = 6;
    localparam int Q  = 8191;

    typedef logic [M-1:0] coef_t;

    typedef struct {
        string name;
        int    nr;
        int    r0, r1, r2;
        coef_t lam0;
        int    deg;
        int    exp_count;
        bit    exp_fail;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 lambda_valid = 1'b0;
    logic                 lambda_ready;
    logic [(T+1)*M-1:0]   lambda = '0;
    logic [CW-1:0]        lambda_deg = '0;
    logic                 err_valid, err_flag, done, fail;
    logic [12:0]          err_pos;
    logic [CW-1:0]        err_count;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    coef_t exp_tab [0:Q-1];
    int    log_tab [0:Q];
    coef_t cur_c   [0:T];
    bit    exp_flag[0:N-1];
    int    roots_q [$];
    vec_t  vecs    [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bch_chien_search #(.T(T), .N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lambda_valid (lambda_valid),
        .lambda_ready (lambda_ready),
        .lambda       (lambda),
        .lambda_deg   (lambda_deg),
        .err_valid    (err_valid),
        .err_flag     (err_flag),
        .err_pos      (err_pos),
        .done         (done),
        .err_count    (err_count),
        .fail         (fail)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic build_tables();
        coef_t x = coef_t'(1);
        for (int i = 0; i < Q; i++) begin
            exp_tab[i] = x;
            log_tab[x] = i;
            x = {x[M-2:0], 1'b0} ^ (x[M-1] ? coef_t'(13'h001B) : coef_t'(0));
        end
    endtask

    function automatic coef_t gmul(input coef_t a, input coef_t b);
        if (a == 0 || b == 0) return '0;
        return exp_tab[(log_tab[a] + log_tab[b]) % Q];
    endfunction

    // Lambda = lam0 * prod(1 + alpha^p x) over the error positions in roots_q.
    task automatic build_poly(input coef_t lam0);
        coef_t a;
        for (int j = 0; j <= T; j++) cur_c[j] = '0;
        cur_c[0] = coef_t'(1);
        foreach (roots_q[i]) begin
            a = exp_tab[roots_q[i]];
            for (int j = T; j >= 1; j--) cur_c[j] ^= gmul(a, cur_c[j-1]);
        end
        for (int j = 0; j <= T; j++) cur_c[j] = gmul(lam0, cur_c[j]);
    endtask

    // An error at bit p means Lambda(alpha^-p) == 0; evaluated by Horner's rule.
    function automatic bit is_root(input int p);
        coef_t x = exp_tab[(Q - p) % Q];
        coef_t s = '0;
        for (int j = T; j >= 0; j--) s = gmul(s, x) ^ cur_c[j];
        return (s == 0);
    endfunction

    task automatic pack_lambda();
        for (int j = 0; j <= T; j++) lambda[j*M +: M] = cur_c[j];
    endtask

    task automatic search(input int deg, input int exp_count, input bit exp_fail,
                          input bit hold, input string name, output int acc);
        int waitc = 0;
        int valid_err = 0, pos_err = 0, flag_err = 0, done_err = 0;
        pack_lambda();
        lambda_deg   = CW'(deg);
        lambda_valid = 1'b1;
        while (!lambda_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({name, " ready_before"}, lambda_ready, 1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        check({name, " ready_drop"}, lambda_ready, 0);
        check({name, " valid_latency"}, err_valid, 0);
        if (!hold) lambda_valid = 1'b0;
        for (int i = 1; i <= N + 2; i++) begin
            @(negedge clk);
            if (i <= N) begin
                if (err_valid !== 1'b1)         valid_err++;
                if (err_pos !== 13'(N - i))     pos_err++;
                if (err_flag !== exp_flag[N-i]) flag_err++;
                if (done !== 1'b0)              done_err++;
            end else if (i == N + 1) begin
                check({name, " done"},      done, 1);
                check({name, " valid_end"}, err_valid, 0);
                check({name, " count"},     err_count, exp_count);
                check({name, " fail"},      fail, exp_fail);
                check({name, " ready_fin"}, lambda_ready, 0);
            end else begin
                check({name, " done_once"}, done, 0);
                check({name, " ready_ret"}, lambda_ready, 1);
            end
            if (hold && i == 500) begin
                for (int j = 0; j <= T; j++) lambda[j*M +: M] = coef_t'($urandom);
                lambda_deg = CW'($urandom);
            end
        end
        check({name, " valid_gaps"},   valid_err, 0);
        check({name, " pos_errs"},     pos_err, 0);
        check({name, " flag_errs"},    flag_err, 0);
        check({name, " early_done"},   done_err, 0);
    endtask

    initial begin
        int acc1, acc2, bad, cnt, deg, nr, waitc, p;
        coef_t lam0;
        bit used [0:N-1];

        build_tables();
        vecs[0] = '{"no_err",       0, 0,   0, 0,     coef_t'(1), 0,  0,  1'b0};
        vecs[1] = '{"single_p100",  1, 100, 0, 0,     coef_t'(1), 1,  1,  1'b0};
        vecs[2] = '{"three_err",    3, 0,   5, N - 1, exp_tab[7], 3,  3,  1'b0};
        vecs[3] = '{"deg_mismatch", 2, 20,  300, 0,   coef_t'(1), 3,  2,  1'b1};
        vecs[4] = '{"lam0_zero",    0, 0,   0, 0,     coef_t'(0), 0,  63, 1'b1};
        vecs[5] = '{"deg_over_t",   1, 9,   0, 0,     coef_t'(1), 40, 1,  1'b1};

        #12;
        check("rst err_valid", err_valid, 0);
        check("rst err_flag", err_flag, 0);
        check("rst err_pos", err_pos, 0);
        check("rst done", done, 0);
        check("rst err_count", err_count, 0);
        check("rst fail", fail, 0);
        check("rst ready", lambda_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_at_release", lambda_ready, 0);
        @(negedge clk);
        check("ready_after_release", lambda_ready, 1);

        for (int v = 0; v < 6; v++) begin
            roots_q.delete();
            if (vecs[v].nr > 0) roots_q.push_back(vecs[v].r0);
            if (vecs[v].nr > 1) roots_q.push_back(vecs[v].r1);
            if (vecs[v].nr > 2) roots_q.push_back(vecs[v].r2);
            build_poly(vecs[v].lam0);
            for (int q = 0; q < N; q++) exp_flag[q] = (vecs[v].lam0 == 0);
            foreach (roots_q[i]) exp_flag[roots_q[i]] = 1'b1;
            search(vecs[v].deg, vecs[v].exp_count, vecs[v].exp_fail, 1'b0, vecs[v].name, acc1);
        end

        for (int round = 0; round < 4; round++) begin
            roots_q.delete();
            for (int q = 0; q < N; q++) used[q] = 1'b0;
            nr = $urandom_range(0, T);
            while (roots_q.size() < nr) begin
                p = $urandom_range(0, N - 1);
                if (!used[p]) begin
                    used[p] = 1'b1;
                    roots_q.push_back(p);
                end
            end
            lam0 = coef_t'($urandom_range(1, Q));
            build_poly(lam0);
            cnt = 0;
            for (int q = 0; q < N; q++) begin
                exp_flag[q] = is_root(q);
                cnt += int'(exp_flag[q]);
            end
            deg = nr + (($urandom_range(0, 3) == 0) ? 1 : 0);
            search(deg, (cnt > 63) ? 63 : cnt, (cnt != deg) || (deg > T), 1'b0, "random", acc1);
        end

        // Valid held high across a whole search, with lambda scrambled mid-search.
        roots_q.delete();
        roots_q.push_back(100);
        build_poly(coef_t'(1));
        for (int q = 0; q < N; q++) exp_flag[q] = (q == 100);
        search(1, 1, 1'b0, 1'b1, "hold_first", acc1);
        roots_q.delete();
        roots_q.push_back(5);
        build_poly(coef_t'(1));
        for (int q = 0; q < N; q++) exp_flag[q] = (q == 5);
        search(1, 1, 1'b0, 1'b0, "hold_second", acc2);
        check("turnaround", acc2 - acc1, N + 3);

        // Asynchronous reset at step 500 aborts the search.
        roots_q.delete();
        roots_q.push_back(50);
        build_poly(coef_t'(1));
        pack_lambda();
        lambda_deg   = CW'(1);
        lambda_valid = 1'b1;
        waitc = 0;
        while (!lambda_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk);
        @(negedge clk);
        lambda_valid = 1'b0;
        repeat (500) @(negedge clk);
        check("abort pre_valid", err_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort err_valid", err_valid, 0);
        check("abort err_pos", err_pos, 0);
        check("abort err_count", err_count, 0);
        check("abort ready", lambda_ready, 0);
        check("abort done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || err_valid) bad++;
        end
        check("abort no_done", bad, 0);
        check("abort ready_back", lambda_ready, 1);

        roots_q.delete();
        roots_q.push_back(7);
        build_poly(coef_t'(1));
        for (int q = 0; q < N; q++) exp_flag[q] = (q == 7);
        search(1, 1, 1'b0, 1'b0, "after_reset_p7", acc1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
